// File: rtl/sort_floats_stream.sv
// sort_floats_stream
//   Streaming sorter for groups of N floating-point values. The block loads N
//   elements serially, bubble-sorts them in place using one shared comparator,
//   and then emits them serially in increasing order.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     up_valid/ready    input handshake; up_data carries one FLEN-bit element
//     down_valid/ready  output handshake; down_data carries one sorted element
//     down_last         set on the final (largest) element of a group
//     down_err          set on every beat of a group whose sort saw a NaN
//
//   f_less_or_equal (also in this file) computes a <= b. err is set when
//   either operand is NaN, and res is then 0. Signed zeros compare equal.

module f_less_or_equal #(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] a_i,
  input  logic [FLEN-1:0] b_i,
  output logic            res_o,
  output logic            err_o
);
  localparam int EW = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : 11;
  localparam int MW = FLEN - 1 - EW;

  logic a_nan, b_nan, a_s, b_s, both_zero;
  logic [FLEN-2:0] a_m, b_m;

  assign a_s = a_i[FLEN-1];
  assign b_s = b_i[FLEN-1];
  assign a_m = a_i[FLEN-2:0];
  assign b_m = b_i[FLEN-2:0];
  assign a_nan = (&a_i[FLEN-2 -: EW]) && (|a_i[MW-1:0]);
  assign b_nan = (&b_i[FLEN-2 -: EW]) && (|b_i[MW-1:0]);
  assign both_zero = (a_m == '0) && (b_m == '0);

  always_comb begin
    err_o = a_nan | b_nan;
    res_o = 1'b0;
    if (err_o)              res_o = 1'b0;
    else if (both_zero)     res_o = 1'b1;
    else if (a_s != b_s)    res_o = a_s;       // negative <= positive
    else if (!a_s)          res_o = (a_m <= b_m);
    else                    res_o = (a_m >= b_m); // magnitudes reverse when negative
  end
endmodule

module sort_floats_stream #(
  parameter int N    = 3,
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  input  logic [FLEN-1:0] up_data,
  output logic            up_ready,
  output logic            down_valid,
  output logic [FLEN-1:0] down_data,
  output logic            down_last,
  output logic            down_err,
  input  logic            down_ready
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t                   state_q, state_d;
  logic [N-1:0][FLEN-1:0]   buf_q, buf_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [IW-1:0]            pass_q, pass_d;
  logic [IW-1:0]            j_q, j_d;
  logic                     err_q, err_d;

  logic [IW-1:0]            jn;       // j+1, the right-hand compare slot
  logic [IW-1:0]            last_j;   // final j of the current pass
  logic                     idx_last, pass_done;
  logic                     cmp_res, cmp_err;

  assign jn        = j_q + IW'(1);
  assign last_j    = IW'(N - 2) - pass_q;
  assign idx_last  = (idx_q == IW'(N - 1));
  assign pass_done = (j_q == last_j);

  f_less_or_equal #(.FLEN(FLEN)) u_cmp (
    .a_i   (buf_q[j_q]),
    .b_i   (buf_q[jn]),
    .res_o (cmp_res),
    .err_o (cmp_err)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (up_valid && idx_last)                          state_d = SORT;
      SORT:    if (pass_done && (pass_q == IW'(N - 2)))           state_d = OUT;
      OUT:     if (down_ready && idx_last)                        state_d = LOAD;
      default:                                                    state_d = LOAD;
    endcase
  end

  // Outputs: everything on the downstream side is zero outside OUT.
  always_comb begin
    up_ready   = (state_q == LOAD);
    down_valid = (state_q == OUT);
    down_data  = down_valid ? buf_q[idx_q] : '0;
    down_last  = down_valid && idx_last;
    down_err   = down_valid && err_q;
  end

  // Datapath next-state
  always_comb begin
    buf_d  = buf_q;
    idx_d  = idx_q;
    pass_d = pass_q;
    j_d    = j_q;
    err_d  = err_q;
    unique case (state_q)
      LOAD: if (up_valid) begin
        buf_d[idx_q] = up_data;
        if (idx_last) begin
          idx_d  = '0;
          pass_d = '0;
          j_d    = '0;
          err_d  = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SORT: begin
        // Swap only on a clean strict greater-than; ties stay put (stable)
        // and NaN comparisons leave the pair untouched.
        if (!cmp_res && !cmp_err) begin
          buf_d[j_q] = buf_q[jn];
          buf_d[jn]  = buf_q[j_q];
        end
        err_d = err_q | cmp_err;
        if (pass_done) begin
          j_d    = '0;
          pass_d = pass_q + IW'(1);
          if (pass_q == IW'(N - 2)) idx_d = '0;
        end else begin
          j_d = jn;
        end
      end
      OUT: if (down_ready) begin
        idx_d = idx_last ? '0 : idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      idx_q  <= '0;
      pass_q <= '0;
      j_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      idx_q  <= idx_d;
      pass_q <= pass_d;
      j_q    <= j_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_sort_floats_stream.sv
module tb_sort_floats_stream;
  localparam int FLEN = 64;

  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] P3   = 64'h4008000000000000;
  localparam logic [63:0] PZ   = 64'h0000000000000000;
  localparam logic [63:0] NZ   = 64'h8000000000000000;
  localparam logic [63:0] M1   = 64'hBFF0000000000000;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] P5   = 64'h4014000000000000;
  localparam logic [63:0] M2   = 64'hC000000000000000;
  localparam logic [63:0] H    = 64'h3FE0000000000000;
  localparam logic [63:0] Q    = 64'h3FD0000000000000;
  localparam logic [63:0] E    = 64'h3FC0000000000000;

  logic            clk, rst;
  logic            up_valid, up_ready;
  logic [FLEN-1:0] up_data;
  logic            down_valid, down_last, down_err, down_ready;
  logic [FLEN-1:0] down_data;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        err;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  sort_floats_stream #(.N(3), .FLEN(FLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_last  (down_last),
    .down_err   (down_err),
    .down_ready (down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_group(input logic [63:0] d0, d1, d2, input logic err, input bit cd);
    sb.push_back('{d0, 1'b0, err, cd});
    sb.push_back('{d1, 1'b0, err, cd});
    sb.push_back('{d2, 1'b1, err, cd});
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [63:0] d);
    int n = 0;
    up_valid = 1'b1;
    up_data  = d;
    while (!up_ready && n < 50) begin @(negedge clk); n++; end
    if (!up_ready) chk("send_timeout", 64'(up_ready), 64'd1);
    @(negedge clk);
    up_valid = 1'b0;
    up_data  = '0;
  endtask

  // Drains one group of three beats against the scoreboard.
  task automatic recv_group(input int stall_beat, input int stall_cyc);
    for (int b = 0; b < 3; b++) begin
      int n = 0;
      exp_t e;
      while (!down_valid && n < 40) begin @(negedge clk); n++; end
      chk("beat_valid", 64'(down_valid), 64'd1);
      if (!down_valid || sb.size() == 0) return;
      e = sb.pop_front();
      if (b == stall_beat) begin
        down_ready = 1'b0;
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge clk);
          chk("stall_valid", 64'(down_valid), 64'd1);
          chk("stall_data", down_data, e.data);
        end
        down_ready = 1'b1;
      end
      if (e.chk_data) chk("data", down_data, e.data);
      chk("last", 64'(down_last), 64'(e.last));
      chk("err", 64'(down_err), 64'(e.err));
      chk("up_ready_in_out", 64'(up_ready), 64'd0);
      @(negedge clk);
    end
    chk("up_ready_after", 64'(up_ready), 64'd1);
    chk("valid_after", 64'(down_valid), 64'd0);
    chk("data_after", down_data, 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    chk("rst_down_valid", 64'(down_valid), 64'd0);
    chk("rst_down_data", down_data, 64'd0);
    chk("rst_down_last", 64'(down_last), 64'd0);
    chk("rst_down_err", 64'(down_err), 64'd0);

    // Basic sort with latency check
    push_group(P1, P2, P3, 1'b0, 1'b1);
    send(P3); send(P1); send(P2);
    n = 0;
    while (!down_valid && n < 20) begin
      chk("up_ready_sort", 64'(up_ready), 64'd0);
      @(negedge clk); n++;
    end
    chk("latency", 64'(n), 64'd3);
    recv_group(-1, 0);

    // Backpressure on beat 2
    push_group(P1, P2, P3, 1'b0, 1'b1);
    send(P3); send(P1); send(P2);
    recv_group(1, 5);

    // Ties and stability
    push_group(M1, PZ, NZ, 1'b0, 1'b1);
    send(PZ); send(NZ); send(M1);
    recv_group(-1, 0);

    // NaN group: only err and beat count matter, then a clean group
    push_group(P1, QNAN, P2, 1'b1, 1'b0);
    send(P1); send(QNAN); send(P2);
    recv_group(-1, 0);
    push_group(P1, P2, P3, 1'b0, 1'b1);
    send(P2); send(P3); send(P1);
    recv_group(-1, 0);

    // Reset during SORT
    send(P3); send(P2); send(P1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("rsort_up_ready", 64'(up_ready), 64'd1);
    chk("rsort_valid", 64'(down_valid), 64'd0);
    chk("rsort_data", down_data, 64'd0);

    // Reset during OUT beat 2
    send(P3); send(P2); send(P1);
    n = 0;
    while (!down_valid && n < 20) begin @(negedge clk); n++; end
    chk("rout_beat1", down_data, P1);
    @(negedge clk);
    chk("rout_beat2", down_data, P2);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("rout_up_ready", 64'(up_ready), 64'd1);
    chk("rout_valid", 64'(down_valid), 64'd0);
    chk("rout_data", down_data, 64'd0);
    chk("rout_last", 64'(down_last), 64'd0);

    // Clean group after resets
    push_group(P1, P2, P3, 1'b0, 1'b1);
    send(P2); send(P1); send(P3);
    recv_group(-1, 0);

    // Stalled input, two consecutive groups
    push_group(M2, P5, P5, 1'b0, 1'b1);
    send(P5); @(negedge clk); send(M2); @(negedge clk); @(negedge clk); send(P5);
    recv_group(-1, 0);
    push_group(E, Q, H, 1'b0, 1'b1);
    send(H); @(negedge clk); send(Q); @(negedge clk); send(E);
    recv_group(-1, 0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
